// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: hold / shift right / shift left / load, plus an
// auto-shift burst sequencer. Optional feature macro ROTATE_EN adds a ROT input for rotation.
module universal_shift_register #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIR,
  input  logic             SIL,
  input  logic             START,
  input  logic             DIR,
  input  logic [CNT_W-1:0] LEN,
`ifdef ROTATE_EN
  input  logic             ROT,
`endif
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qb,
  output logic             SOR,
  output logic             SOL,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StFin   = 2'b10
  } state_e;

  localparam logic [1:0] ModeHold  = 2'b00;
  localparam logic [1:0] ModeRight = 2'b01;
  localparam logic [1:0] ModeLeft  = 2'b10;
  localparam logic [1:0] ModeLoad  = 2'b11;

  state_e           r_state;
  state_e           w_state_d;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  logic             r_dir;
  logic             w_dir_d;

  logic             w_rot;
  logic             w_in_r;
  logic             w_in_l;
  logic [WIDTH-1:0] w_q_right;
  logic [WIDTH-1:0] w_q_left;

`ifdef ROTATE_EN
  assign w_rot = ROT;
`else
  assign w_rot = 1'b0;
`endif

  // Rotation feeds the outgoing bit back in place of the serial input.
  assign w_in_r    = w_rot ? r_q[0]       : SIR;
  assign w_in_l    = w_rot ? r_q[WIDTH-1] : SIL;
  assign w_q_right = {w_in_r, r_q[WIDTH-1:1]};
  assign w_q_left  = {r_q[WIDTH-2:0], w_in_l};

  always_comb begin
    w_state_d = r_state;
    w_q_d     = r_q;
    w_cnt_d   = r_cnt;
    w_dir_d   = r_dir;
    unique case (r_state)
      StIdle: begin
        if (START) begin
          // START overrides any manual mode on the same edge.
          if (LEN != '0) begin
            w_state_d = StShift;
            w_cnt_d   = LEN;
            w_dir_d   = DIR;
          end else begin
            w_state_d = StFin;
          end
        end else begin
          unique case (MODE)
            ModeHold:  w_q_d = r_q;
            ModeRight: w_q_d = w_q_right;
            ModeLeft:  w_q_d = w_q_left;
            ModeLoad:  w_q_d = D;
            default:   w_q_d = r_q;
          endcase
        end
      end
      StShift: begin
        w_q_d   = r_dir ? w_q_left : w_q_right;
        w_cnt_d = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_d = StFin;
        end
      end
      StFin: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      r_state <= StIdle;
      r_q     <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_q     <= w_q_d;
      r_cnt   <= w_cnt_d;
      r_dir   <= w_dir_d;
    end
  end

  assign Q    = r_q;
  assign Qb   = ~r_q;
  assign SOR  = r_q[0];
  assign SOL  = r_q[WIDTH-1];
  assign BUSY = (r_state == StShift);
  assign DONE = (r_state == StFin);

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed self-checking bench for universal_shift_register (WIDTH=8, CNT_W=4).
module tb_universal_shift_register;

  logic       CLOCK;
  logic       RESET_N;
  logic [1:0] MODE;
  logic [7:0] D;
  logic       SIR;
  logic       SIL;
  logic       START;
  logic       DIR;
  logic [3:0] LEN;
  logic       ROT;
  logic [7:0] Q;
  logic [7:0] Qb;
  logic       SOR;
  logic       SOL;
  logic       BUSY;
  logic       DONE;

  int checks;
  int failures;

  universal_shift_register #(
    .WIDTH(8),
    .CNT_W(4)
  ) dut (
    .CLOCK  (CLOCK),
    .RESET_N(RESET_N),
    .MODE   (MODE),
    .D      (D),
    .SIR    (SIR),
    .SIL    (SIL),
    .START  (START),
    .DIR    (DIR),
    .LEN    (LEN),
`ifdef ROTATE_EN
    .ROT    (ROT),
`endif
    .Q      (Q),
    .Qb     (Qb),
    .SOR    (SOR),
    .SOL    (SOL),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle_inputs();
    MODE  = 2'b00;
    START = 1'b0;
    SIR   = 1'b0;
    SIL   = 1'b0;
    DIR   = 1'b0;
    LEN   = 4'd0;
    ROT   = 1'b0;
  endtask

  task automatic load(input logic [7:0] val);
    MODE = 2'b11;
    D    = val;
    tick();
    MODE = 2'b00;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    MODE    = 2'b11;
    D       = 8'hA5;
    tick();
    checks++;
    if (Q !== 8'h00) begin
      failures++;
      $display("FAIL reset_q: got %h want %h", Q, 8'h00);
    end
    checks++;
    if (Qb !== 8'hFF) begin
      failures++;
      $display("FAIL reset_qb: got %h want %h", Qb, 8'hFF);
    end
    checks++;
    if ({BUSY, DONE, SOR, SOL} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b want %b", {BUSY, DONE, SOR, SOL}, 4'b0000);
    end
    RESET_N = 1'b1;
    idle_inputs();
    tick();
  endtask

  task automatic test_load_shift();
    load(8'hA5);
    checks++;
    if (Q !== 8'hA5 || Qb !== 8'h5A) begin
      failures++;
      $display("FAIL load: got q=%h qb=%h want q=a5 qb=5a", Q, Qb);
    end
    MODE = 2'b01;
    SIR  = 1'b1;
    tick();
    checks++;
    if (Q !== 8'hD2 || SOR !== 1'b0) begin
      failures++;
      $display("FAIL shift_right: got q=%h sor=%b want q=d2 sor=0", Q, SOR);
    end
    MODE = 2'b10;
    SIL  = 1'b0;
    tick();
    checks++;
    if (Q !== 8'hA4 || SOL !== 1'b1) begin
      failures++;
      $display("FAIL shift_left: got q=%h sol=%b want q=a4 sol=1", Q, SOL);
    end
    MODE = 2'b00;
    SIR  = 1'b1;
    SIL  = 1'b1;
    tick();
    tick();
    checks++;
    if (Q !== 8'hA4) begin
      failures++;
      $display("FAIL hold: got %h want %h", Q, 8'hA4);
    end
    idle_inputs();
  endtask

  task automatic test_burst();
    logic [7:0] exp_q [3];
    exp_q[0] = 8'h40;
    exp_q[1] = 8'h20;
    exp_q[2] = 8'h10;
    load(8'h81);
    START = 1'b1;
    DIR   = 1'b0;
    LEN   = 4'd3;
    SIR   = 1'b0;
    tick();
    START = 1'b0;
    // Manual load while busy must be ignored.
    MODE = 2'b11;
    D    = 8'hFF;
    checks++;
    if (BUSY !== 1'b1 || DONE !== 1'b0 || Q !== 8'h81) begin
      failures++;
      $display("FAIL burst_launch: got busy=%b done=%b q=%h want 1 0 81", BUSY, DONE, Q);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (Q !== exp_q[i]) begin
        failures++;
        $display("FAIL burst_step%0d: got %h want %h", i, Q, exp_q[i]);
      end
      if (i < 2) begin
        checks++;
        if (BUSY !== 1'b1 || DONE !== 1'b0) begin
          failures++;
          $display("FAIL burst_busy%0d: got busy=%b done=%b want 1 0", i, BUSY, DONE);
        end
      end
    end
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b1) begin
      failures++;
      $display("FAIL burst_done: got busy=%b done=%b want 0 1", BUSY, DONE);
    end
    MODE = 2'b00;
    tick();
    checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || Q !== 8'h10) begin
      failures++;
      $display("FAIL burst_after: got done=%b busy=%b q=%h want 0 0 10", DONE, BUSY, Q);
    end
    idle_inputs();
  endtask

  task automatic test_len_zero();
    load(8'h5A);
    START = 1'b1;
    LEN   = 4'd0;
    MODE  = 2'b11;
    D     = 8'hFF;
    tick();
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b1 || Q !== 8'h5A) begin
      failures++;
      $display("FAIL len0_done: got busy=%b done=%b q=%h want 0 1 5a", BUSY, DONE, Q);
    end
    // START during the DONE cycle is ignored.
    START = 1'b1;
    LEN   = 4'd2;
    MODE  = 2'b00;
    tick();
    START = 1'b0;
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || Q !== 8'h5A) begin
      failures++;
      $display("FAIL start_in_fin: got busy=%b done=%b q=%h want 0 0 5a", BUSY, DONE, Q);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    load(8'h01);
    START = 1'b1;
    DIR   = 1'b1;
    LEN   = 4'd2;
    tick();
    START = 1'b0;
    DIR   = 1'b0;
    SIL   = 1'b1;
    tick();
    tick();
    checks++;
    if (DONE !== 1'b1 || Q !== 8'h07) begin
      failures++;
      $display("FAIL left_burst: got done=%b q=%h want 1 07", DONE, Q);
    end
    tick();
    // Relaunch straight from IDLE with a one-shift burst.
    START = 1'b1;
    DIR   = 1'b0;
    LEN   = 4'd1;
    SIR   = 1'b1;
    tick();
    START = 1'b0;
    tick();
    checks++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || Q !== 8'h83) begin
      failures++;
      $display("FAIL len1_burst: got done=%b busy=%b q=%h want 1 0 83", DONE, BUSY, Q);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    int done_seen;
    load(8'hF0);
    START = 1'b1;
    LEN   = 4'd5;
    tick();
    START = 1'b0;
    tick();
    checks++;
    if (BUSY !== 1'b1) begin
      failures++;
      $display("FAIL midburst_busy: got %b want 1", BUSY);
    end
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    checks++;
    if (Q !== 8'h00 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      failures++;
      $display("FAIL midburst_reset: got q=%h busy=%b done=%b want 00 0 0", Q, BUSY, DONE);
    end
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (DONE === 1'b1 || BUSY === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      failures++;
      $display("FAIL midburst_no_done: got %0d busy/done cycles want 0", done_seen);
    end
  endtask

  task automatic test_rotate();
    load(8'h81);
    ROT  = 1'b1;
    SIR  = 1'b0;
    SIL  = 1'b0;
    MODE = 2'b01;
    tick();
`ifdef ROTATE_EN
    checks++;
    if (Q !== 8'hC0) begin
      failures++;
      $display("FAIL rotate_right: got %h want %h", Q, 8'hC0);
    end
    MODE = 2'b10;
    tick();
    tick();
    checks++;
    if (Q !== 8'h03) begin
      failures++;
      $display("FAIL rotate_left: got %h want %h", Q, 8'h03);
    end
`else
    checks++;
    if (Q !== 8'h40) begin
      failures++;
      $display("FAIL norotate_right: got %h want %h", Q, 8'h40);
    end
`endif
    idle_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RESET_N  = 1'b0;
    D        = 8'h00;
    idle_inputs();
    test_reset();
    test_load_shift();
    test_burst();
    test_len_zero();
    test_back_to_back();
    test_reset_mid_burst();
    test_rotate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
